// File: rtl/sd_ramdisk.sv
// Serves 512-byte SD sectors out of an SDRAM disk image.
// Define SD_RAMDISK_WP_EN to make the image write-protected.
module sd_ramdisk #(
    parameter logic [22:0] IMG_BASE    = 23'h600000,
    parameter logic [31:0] MAX_SECTORS = 32'd1440
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [31:0] sd_lba,
    input  logic        sd_rd,
    input  logic        sd_wr,
    output logic        sd_ack,
    output logic [8:0]  sd_buff_addr,
    output logic [7:0]  sd_buff_dout,
    input  logic [7:0]  sd_buff_din,
    output logic        sd_buff_wr,
    output logic [22:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    input  logic        mem_ready
);

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_PUT, WR_FETCH, WR_REQ, NEXT, DONE
    } state_t;

    state_t      state;
    logic [31:0] lba;
    logic        is_rd;
    logic        fetch_dly;
    logic        rd_oor;
    logic        wr_block;

    assign rd_oor = (lba >= MAX_SECTORS);

`ifdef SD_RAMDISK_WP_EN
    assign wr_block = 1'b1;
`else
    assign wr_block = rd_oor;
`endif

    // Only lba[13:0] reaches the 23-bit SDRAM address space.
    assign mem_addr = IMG_BASE + {lba[13:0], 9'b0} + {14'b0, sd_buff_addr};

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            lba          <= '0;
            is_rd        <= 1'b0;
            fetch_dly    <= 1'b0;
            sd_ack       <= 1'b0;
            sd_buff_addr <= '0;
            sd_buff_dout <= 8'h00;
            sd_buff_wr   <= 1'b0;
            mem_rd       <= 1'b0;
            mem_wr       <= 1'b0;
            mem_dout     <= 8'h00;
        end else begin
            unique case (state)
                IDLE: begin
                    if (sd_rd) begin
                        lba    <= sd_lba;
                        sd_ack <= 1'b1;
                        is_rd  <= 1'b1;
                        state  <= RD_REQ;
                    end else if (sd_wr) begin
                        lba    <= sd_lba;
                        sd_ack <= 1'b1;
                        is_rd  <= 1'b0;
                        state  <= WR_FETCH;
                    end
                end
                RD_REQ: begin
                    if (rd_oor) begin
                        sd_buff_dout <= 8'hFF;
                        sd_buff_wr   <= 1'b1;
                        state        <= RD_PUT;
                    end else if (mem_rd && mem_ready) begin
                        mem_rd       <= 1'b0;
                        sd_buff_dout <= mem_din;
                        sd_buff_wr   <= 1'b1;
                        state        <= RD_PUT;
                    end else begin
                        mem_rd <= 1'b1;
                    end
                end
                RD_PUT: begin
                    sd_buff_wr <= 1'b0;
                    state      <= NEXT;
                end
                // The buffer answers one cycle after the address moves.
                WR_FETCH: begin
                    if (!fetch_dly) begin
                        fetch_dly <= 1'b1;
                    end else begin
                        fetch_dly <= 1'b0;
                        mem_dout  <= sd_buff_din;
                        mem_wr    <= !wr_block;
                        state     <= WR_REQ;
                    end
                end
                WR_REQ: begin
                    if (wr_block) begin
                        state <= NEXT;
                    end else if (mem_wr && mem_ready) begin
                        mem_wr <= 1'b0;
                        state  <= NEXT;
                    end
                end
                NEXT: begin
                    if (sd_buff_addr == 9'd511) begin
                        state <= DONE;
                    end else begin
                        sd_buff_addr <= sd_buff_addr + 9'd1;
                        state        <= is_rd ? RD_REQ : WR_FETCH;
                    end
                end
                DONE: begin
                    sd_ack       <= 1'b0;
                    sd_buff_addr <= '0;
                    if (!sd_rd && !sd_wr) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_ramdisk.sv
// Directed bench for sd_ramdisk: sector reads, writes, range limits,
// request contention, re-trigger, mid-transfer reset and address wrap.
module tb_sd_ramdisk;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] sd_lba  = '0;
    logic        sd_rd   = 1'b0;
    logic        sd_wr   = 1'b0;
    logic        sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic [7:0]  sd_buff_din = 8'h00;
    logic        sd_buff_wr;
    logic [22:0] mem_addr;
    logic        mem_rd, mem_wr;
    logic [7:0]  mem_din = 8'h00;
    logic [7:0]  mem_dout;
    logic        mem_ready = 1'b0;

    logic        w_ack, w_bwr, w_rd, w_wr;
    logic [8:0]  w_baddr;
    logic [7:0]  w_bdout, w_mdout;
    logic [22:0] w_addr;

    always #5 clk_sys = ~clk_sys;

    sd_ramdisk dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .sd_lba(sd_lba),
        .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_din(sd_buff_din), .sd_buff_wr(sd_buff_wr),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_ready(mem_ready)
    );

    // Runs in lockstep with dut; only its address is observed.
    sd_ramdisk #(.IMG_BASE(23'h7FFF00)) u_wrap (
        .clk_sys(clk_sys), .reset_n(reset_n), .sd_lba(sd_lba),
        .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(w_ack),
        .sd_buff_addr(w_baddr), .sd_buff_dout(w_bdout),
        .sd_buff_din(sd_buff_din), .sd_buff_wr(w_bwr),
        .mem_addr(w_addr), .mem_rd(w_rd), .mem_wr(w_wr),
        .mem_din(8'h00), .mem_dout(w_mdout), .mem_ready(mem_ready)
    );

    logic [7:0] mem [logic [22:0]];

    function automatic logic [7:0] memval(input logic [22:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ a[15:8] ^ 8'hC3;
    endfunction

    // SDRAM: ready pulse three cycles after a request rises.
    int cnt = 0;
    always @(posedge clk_sys) begin
        mem_ready <= 1'b0;
        if ((mem_rd || mem_wr) && !mem_ready) begin
            if (cnt == 2) begin
                mem_ready <= 1'b1;
                cnt <= 0;
                if (mem_wr) mem[mem_addr] = mem_dout;
                else mem_din <= memval(mem_addr);
            end else begin
                cnt <= cnt + 1;
            end
        end else begin
            cnt <= 0;
        end
    end

    always @(posedge clk_sys) sd_buff_din <= sd_buff_addr[7:0] ^ 8'h5A;

    int          x_rd, x_wr, x_strb, x_derr, x_aerr, x_both;
    logic [22:0] x_first, x_last, w255, w256;
    logic        ack_d = 1'b0;
    logic [7:0]  exp_b;

    always @(negedge clk_sys) begin
        ack_d <= sd_ack;
        if (sd_ack && !ack_d) begin
            x_rd = 0; x_wr = 0; x_strb = 0; x_derr = 0;
            x_aerr = 0; x_both = 0; x_first = 23'h7FFFFF;
        end
        if (mem_rd && mem_wr) x_both++;
        if (mem_ready && (mem_rd || mem_wr)) begin
            if (x_rd + x_wr == 0) x_first = mem_addr;
            else if (mem_addr != x_last + 23'd1) x_aerr++;
            x_last = mem_addr;
            if (mem_rd && x_rd == 255) w255 = w_addr;
            if (mem_rd && x_rd == 256) w256 = w_addr;
            if (mem_rd) x_rd++;
            else x_wr++;
        end
        if (sd_buff_wr) begin
            x_strb++;
            if (sd_lba >= 32'd1440) exp_b = 8'hFF;
            else exp_b = memval(23'h600000 + {sd_lba[13:0], 9'b0}
                                + {14'b0, sd_buff_addr});
            if (sd_buff_dout != exp_b) x_derr++;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_ack(input logic v, input int maxc, input string nm);
        int n = 0;
        while (sd_ack !== v && n < maxc) begin
            @(negedge clk_sys);
            n++;
        end
        if (sd_ack !== v) begin
            checks++;
            errors++;
            $display("FAIL %s: sd_ack got %b expected %b", nm, sd_ack, v);
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] lba;
        int          e_rd;
        int          e_wr;
        int          e_strb;
        logic [22:0] e_first;
    } vec_t;

    vec_t vt [6];
    int   bad;
    int   hi;

`ifdef SD_RAMDISK_WP_EN
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif

    initial begin
        vt[0] = '{1'b1, 1'b0, 32'd2,    512, 0, 512, 23'h600400};
        vt[1] = '{1'b0, 1'b1, 32'd0,    0, WP ? 0 : 512, 0,
                  WP ? 23'h7FFFFF : 23'h600000};
        vt[2] = '{1'b1, 1'b0, 32'd0,    512, 0, 512, 23'h600000};
        vt[3] = '{1'b1, 1'b0, 32'd1440, 0, 0, 512, 23'h7FFFFF};
        vt[4] = '{1'b1, 1'b1, 32'd3,    512, 0, 512, 23'h600600};
        vt[5] = '{1'b0, 1'b1, 32'd1440, 0, 0, 0, 23'h7FFFFF};

        repeat (3) @(negedge clk_sys);
        chk("reset_outputs",
            {31'b0, sd_ack, sd_buff_wr, mem_rd, mem_wr, sd_buff_addr,
             sd_buff_dout, mem_dout}, 32'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_sys);

        for (int i = 0; i < 6; i++) begin
            sd_lba = vt[i].lba;
            sd_rd  = vt[i].rd;
            sd_wr  = vt[i].wr;
            wait_ack(1'b1, 10, $sformatf("v%0d_start", i));
            wait_ack(1'b0, 20000, $sformatf("v%0d_end", i));
            sd_rd = 1'b0;
            sd_wr = 1'b0;
            repeat (3) @(negedge clk_sys);
            chk($sformatf("v%0d_rd_hs", i), x_rd, vt[i].e_rd);
            chk($sformatf("v%0d_wr_hs", i), x_wr, vt[i].e_wr);
            chk($sformatf("v%0d_strobes", i), x_strb, vt[i].e_strb);
            chk($sformatf("v%0d_data_err", i), x_derr, 0);
            chk($sformatf("v%0d_addr_step", i), x_aerr + x_both, 0);
            chk($sformatf("v%0d_first_addr", i), x_first, vt[i].e_first);
            if (i == 1) begin
                bad = 0;
                for (int b = 0; b < 512; b++) begin
                    logic [22:0] a;
                    logic [8:0]  bi;
                    a  = 23'h600000 + 23'(b);
                    bi = 9'(b);
                    if (memval(a) != (WP ? (a[7:0] ^ a[15:8] ^ 8'hC3)
                                         : (bi[7:0] ^ 8'h5A))) bad++;
                end
                chk("write_contents", bad, 0);
            end
            if (i == 2) begin
                chk("wrap_byte255", w255, 23'h7FFFFF);
                chk("wrap_byte256", w256, 23'h000000);
            end
        end

        // Held request must not start a second transfer.
        sd_lba = 32'd1440;
        sd_rd  = 1'b1;
        wait_ack(1'b1, 10, "retrig_start");
        wait_ack(1'b0, 20000, "retrig_end");
        hi = 0;
        repeat (20) begin
            @(negedge clk_sys);
            if (sd_ack) hi++;
        end
        chk("retrigger_held", hi, 0);
        sd_rd = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("retrigger_dropped", {31'b0, sd_ack}, 0);

        // Reset in the middle of a read, request left high.
        sd_lba = 32'd1;
        sd_rd  = 1'b1;
        wait_ack(1'b1, 10, "mid_start");
        hi = 0;
        while (sd_buff_addr != 9'd100 && hi < 5000) begin
            @(negedge clk_sys);
            hi++;
        end
        chk("mid_reached_100", {23'b0, sd_buff_addr}, 32'd100);
        reset_n = 1'b0;
        #1;
        chk("mid_reset_outputs",
            {31'b0, sd_ack, sd_buff_wr, mem_rd, mem_wr, sd_buff_addr,
             sd_buff_dout, mem_dout}, 32'h0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        wait_ack(1'b1, 10, "restart_start");
        wait_ack(1'b0, 20000, "restart_end");
        sd_rd = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("restart_first_addr", x_first, 23'h600200);
        chk("restart_rd_hs", x_rd, 512);
        chk("restart_data_err", x_derr, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sd_ramdisk.md
SD_RAMDISK -- requirements
Module: sd_ramdisk

Interface
REQ-001 SHALL have parameter IMG_BASE, default 23'h600000: byte address of image sector 0 in SDRAM.
REQ-002 SHALL have parameter MAX_SECTORS, default 32'd1440: number of sectors backed by SDRAM.
REQ-003 SHALL have port clk_sys, input, 1: sole clock, all logic on rising edge.
REQ-004 SHALL have port reset_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port sd_lba, input, 32: sector number from the disk controller.
REQ-006 SHALL have port sd_rd, input, 1: sector read request, level.
REQ-007 SHALL have port sd_wr, input, 1: sector write request, level.
REQ-008 SHALL have port sd_ack, output, 1: transfer in progress.
REQ-009 SHALL have port sd_buff_addr, output, 9: byte index within the sector.
REQ-010 SHALL have port sd_buff_dout, output, 8: read data to the controller buffer.
REQ-011 SHALL have port sd_buff_din, input, 8: write data from the controller buffer, valid 1 cycle after sd_buff_addr changes.
REQ-012 SHALL have port sd_buff_wr, output, 1: one-cycle strobe that sd_buff_dout is valid at sd_buff_addr.
REQ-013 SHALL have port mem_addr, output, 23: SDRAM byte address.
REQ-014 SHALL have ports mem_rd and mem_wr, output, 1 each: SDRAM requests, held until mem_ready.
REQ-015 SHALL have port mem_din, input, 8: SDRAM read data, valid with mem_ready.
REQ-016 SHALL have port mem_dout, output, 8: SDRAM write data.
REQ-017 SHALL have port mem_ready, input, 1: one-cycle completion pulse from SDRAM.

Function
REQ-018 SHALL use FSM states IDLE, RD_REQ, RD_PUT, WR_FETCH, WR_REQ, NEXT, DONE.
REQ-019 IDLE: if sd_rd, latch sd_lba, set sd_ack, and go to RD_REQ; else if sd_wr, do the same and go to WR_FETCH. Read SHALL win when both are high.
REQ-020 Memory address SHALL be (IMG_BASE + {lba,9'b0} + sd_buff_addr) mod 2^23.
REQ-021 RD_REQ: assert mem_rd. On mem_ready, register mem_din into sd_buff_dout and go to RD_PUT.
REQ-022 RD_PUT: pulse sd_buff_wr for exactly one cycle, then go to NEXT.
REQ-023 WR_FETCH: wait one cycle, sample sd_buff_din into mem_dout, then go to WR_REQ.
REQ-024 WR_REQ: assert mem_wr. On mem_ready, go to NEXT.
REQ-025 NEXT: if sd_buff_addr == 511, go to DONE. Otherwise increment sd_buff_addr and return to RD_REQ or WR_FETCH.
REQ-026 DONE: clear sd_ack, zero sd_buff_addr, and return to IDLE only when sd_rd and sd_wr are both low. This prevents a level request from being re-triggered.
REQ-027 Out of range (latched lba >= MAX_SECTORS):
- Read: no mem_rd is issued; sd_buff_dout = 8'hFF; all 512 sd_buff_wr strobes are still produced.
- Write: no mem_wr is issued; the data is discarded; sd_ack still spans 512 byte steps.
REQ-028 sd_rd/sd_wr changes while sd_ack is high SHALL be ignored.
REQ-029 mem_rd and mem_wr SHALL never be high together and SHALL each be low outside their own request state.
REQ-030 A full in-range read SHALL issue exactly 512 mem_rd handshakes, with addresses incrementing by 1.

Reset
REQ-031 reset_n low SHALL force, immediately and asynchronously:
- state to IDLE;
- sd_ack, sd_buff_wr, mem_rd, mem_wr to 0;
- sd_buff_addr to 0;
- sd_buff_dout and mem_dout to 8'h00;
- latched lba to 0.
REQ-032 Reset mid-transfer SHALL abandon the sector without further memory accesses.
REQ-033 After reset_n rises, a request still held high SHALL start a new transfer from byte 0.

Configuration
REQ-034 Macro SD_RAMDISK_WP_EN, when defined, SHALL enable write protection:
- every sd_wr is treated as out of range for writes (no mem_wr is ever issued);
- the full sd_ack handshake is preserved.
REQ-035 Without SD_RAMDISK_WP_EN, in-range writes SHALL reach SDRAM per REQ-023/024.

Verification
REQ-036 Read: sd_rd=1, lba=2, mem_ready 3 cycles after each request.
- mem_addr runs 0x600400..0x6005FF.
- 512 sd_buff_wr pulses occur with matching data.
- sd_ack falls after byte 511.
REQ-037 Write: sd_wr=1, lba=0, buffer pattern addr^8'h5A.
- SDRAM 0x600000..0x6001FF holds the pattern.
- With SD_RAMDISK_WP_EN, there are zero mem_wr and SDRAM is unchanged.
REQ-038 Out of range: sd_rd with lba=1440 -> 512 strobes of 8'hFF, no mem_rd.
REQ-039 Contention and re-trigger:
- sd_rd and sd_wr both high -> read performed.
- Request held high after DONE -> no second transfer until the request drops.
REQ-040 Reset mid-operation: reset_n pulsed low at byte 100 of a read -> all outputs 0 within the same cycle. With sd_rd still high after release, the read restarts at mem_addr base + 0.
REQ-041 Wrap: IMG_BASE=23'h7FFF00, lba=0 -> mem_addr wraps from 0x7FFFFF to 0x000000 at byte 256.
